// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: control-word bit constants, opcodes, the
// fetch words, the trace record layout, the decoder step encoding and the
// single microcode source expected_ctrl() used by the control unit and the
// trace decoder.
//
// No ports (package).
package cpu_ctrl_pkg;

    localparam int CTRL_W = 17;
    typedef logic [CTRL_W-1:0] ctrl_t;

    // Control-word bits, MSB (OUT_EN) down to LSB (CLK_HLT).
    // *_READ loads a register from the bus, *_WRITE drives the bus.
    localparam ctrl_t OUT_EN    = ctrl_t'(1 << 16);
    localparam ctrl_t SUB       = ctrl_t'(1 << 15);
    localparam ctrl_t ALU_WRITE = ctrl_t'(1 << 14);
    localparam ctrl_t A_READ    = ctrl_t'(1 << 13);
    localparam ctrl_t A_WRITE   = ctrl_t'(1 << 12);
    localparam ctrl_t B_READ    = ctrl_t'(1 << 11);
    localparam ctrl_t B_WRITE   = ctrl_t'(1 << 10);
    localparam ctrl_t I_READ    = ctrl_t'(1 << 9);
    localparam ctrl_t I_WRITE   = ctrl_t'(1 << 8);
    localparam ctrl_t RAM_READ  = ctrl_t'(1 << 7);
    localparam ctrl_t RAM_WRITE = ctrl_t'(1 << 6);
    localparam ctrl_t MAR_READ  = ctrl_t'(1 << 5);
    localparam ctrl_t PC_OUT    = ctrl_t'(1 << 4);
    localparam ctrl_t PC_INC    = ctrl_t'(1 << 3);
    localparam ctrl_t PC_JUMP   = ctrl_t'(1 << 2);
    localparam ctrl_t FLAG_READ = ctrl_t'(1 << 1);
    localparam int    CLK_HLT_BIT = 0;
    localparam ctrl_t CLK_HLT   = ctrl_t'(1 << CLK_HLT_BIT);

    localparam ctrl_t FETCH0 = PC_OUT | MAR_READ;
    localparam ctrl_t FETCH1 = RAM_WRITE | I_READ | PC_INC;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_TBA = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic       err;
        logic [3:0] pc;
        logic [3:0] opcode;
        logic [3:0] operand;
        logic [7:0] data;
    } trace_rec_t;

    // Encoding doubles as the micro-step index (IDLE waits for step 0).
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5,
        ST_S6   = 3'd6
    } step_t;

    function automatic ctrl_t expected_ctrl(input logic [3:0] opcode,
                                            input logic [2:0] step,
                                            input logic       carry,
                                            input logic       zero);
        ctrl_t w;
        w = '0;
        case (step)
            3'd0: w = FETCH0;
            3'd1: w = FETCH1;
            3'd2: begin
                case (opcode)
                    OP_NOP:                         w = '0;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w = I_WRITE | MAR_READ;
                    OP_LDI:                         w = I_WRITE | A_READ;
                    OP_JMP:                         w = I_WRITE | PC_JUMP;
                    OP_JC:  w = carry ? (I_WRITE | PC_JUMP) : '0;
                    OP_JZ:  w = zero  ? (I_WRITE | PC_JUMP) : '0;
                    OP_TBA:                         w = B_WRITE | A_READ;
                    OP_OUT:                         w = A_WRITE | OUT_EN;
                    OP_HLT:                         w = CLK_HLT;
                    default:                        w = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         w = RAM_WRITE | A_READ;
                    OP_ADD, OP_SUB: w = RAM_WRITE | B_READ;
                    OP_STA:         w = A_WRITE | RAM_READ;
                    default:        w = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  w = ALU_WRITE | A_READ | FLAG_READ;
                    OP_SUB:  w = ALU_WRITE | SUB | A_READ | FLAG_READ;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with count-based full/empty. A push while full is only
// accepted when a pop happens on the same edge. rd_data shows the head
// combinationally and reads as zero when the FIFO is empty.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   push        write request, wr_data stored if accepted
//   pop         remove head (ignored when empty)
//   rd_data     head entry, 0 when empty
//   empty/full  occupancy status
module trace_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_data = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_trace_decoder.sv
// Passive trace decoder: follows the 17-bit control word step by step,
// checks every micro-step against expected_ctrl(), and emits one trace
// record per retired instruction through a valid/ready FIFO.
//
// Ports:
//   clk, rst_n      CPU clock, asynchronous active-low reset
//   ctrl_word       control word as driven by the control unit
//   bus             CPU data bus
//   alu_carry/zero  flag-register outputs seen by the control unit
//   trace_valid     FIFO holds at least one record
//   trace_ready     consumer pops the head when valid && ready
//   trace_data      head record {err,pc,opcode,operand,data}, 0 when empty
//   trace_overflow  sticky: a record was dropped on a full FIFO
//   sync_lost       sticky: FETCH0 arrived mid-instruction
module instr_trace_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STEPS      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] ctrl_word,
    input  logic [7:0]  bus,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [20:0] trace_data,
    output logic        trace_overflow,
    output logic        sync_lost
);

    localparam step_t LAST_STEP = step_t'(3'(STEPS - 1));

    step_t      state;
    trace_rec_t rec_q;
    trace_rec_t rec_next;
    trace_rec_t push_rec;
    ctrl_t      exp_word;
    logic       is_fetch0;
    logic       resync;
    logic       halt_push;
    logic       last_push;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;

    always_comb begin
        exp_word  = expected_ctrl(rec_q.opcode, state, alu_carry, alu_zero);
        is_fetch0 = (ctrl_word == FETCH0);
        resync    = (state != ST_IDLE) && is_fetch0;

        // Record as it stands after folding in this cycle's execute step.
        rec_next = rec_q;
        if (state >= ST_S2) begin
            if (ctrl_word != exp_word) rec_next.err = 1'b1;
            if (exp_word != '0)        rec_next.data = bus;
        end

        // The clock stops once CLK_HLT is asserted, so HLT must push now.
        halt_push = (state == ST_S2) && ctrl_word[CLK_HLT_BIT] && !resync;
        last_push = (state == LAST_STEP) && !resync;
        push      = resync || halt_push || last_push;

        // A resync closes the interrupted record without this cycle's step.
        push_rec = rec_next;
        if (resync) begin
            push_rec     = rec_q;
            push_rec.err = 1'b1;
        end

        trace_valid = !fifo_empty;
        pop         = trace_valid && trace_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            sync_lost      <= 1'b0;
            trace_overflow <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) trace_overflow <= 1'b1;
            if (resync)                    sync_lost      <= 1'b1;
            case (state)
                ST_IDLE: if (is_fetch0) state <= ST_S1;
                default: begin
                    if (resync)                      state <= ST_S1;
                    else if (halt_push || last_push) state <= ST_IDLE;
                    else                             state <= step_t'(state + 3'd1);
                end
            endcase
        end
    end

    // Record fields; a FETCH0 in any state opens a fresh record.
    always_ff @(posedge clk) begin
        if (is_fetch0) begin
            rec_q.err     <= 1'b0;
            rec_q.pc      <= bus[3:0];
            rec_q.opcode  <= 4'h0;
            rec_q.operand <= 4'h0;
            rec_q.data    <= 8'h00;
        end else if (state == ST_S1) begin
            rec_q.opcode  <= bus[7:4];
            rec_q.operand <= bus[3:0];
            if (ctrl_word != FETCH1) rec_q.err <= 1'b1;
        end else begin
            rec_q <= rec_next;
        end
    end

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_rec),
        .pop     (pop),
        .rd_data (trace_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_instr_trace_decoder.sv
// Directed bench for instr_trace_decoder: drives control words on negedge,
// checks outputs 1 time unit after posedge against hand-computed records.
module tb_instr_trace_decoder;
    import cpu_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [16:0] ctrl_word;
    logic [7:0]  bus;
    logic        alu_carry;
    logic        alu_zero;
    logic        trace_valid;
    logic        trace_ready;
    logic [20:0] trace_data;
    logic        trace_overflow;
    logic        sync_lost;

    int n_assert = 0;
    int n_fail   = 0;

    instr_trace_decoder #(.FIFO_DEPTH(4), .STEPS(7)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_word      (ctrl_word),
        .bus            (bus),
        .alu_carry      (alu_carry),
        .alu_zero       (alu_zero),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow),
        .sync_lost      (sync_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [20:0] rec(input logic e, input logic [3:0] p,
                                        input logic [3:0] o, input logic [3:0] r,
                                        input logic [7:0] d);
        return {e, p, o, r, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input ctrl_t c, input logic [7:0] b);
        @(negedge clk);
        ctrl_word = c;
        bus       = b;
    endtask

    // Full 7-step instruction; steps 5 and 6 drive 0. rdy6 asserts
    // trace_ready only for the final step's edge.
    task automatic instr(input logic [3:0] pc, input logic [3:0] op, input logic [3:0] opr,
                         input ctrl_t c2, input ctrl_t c3, input ctrl_t c4,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                         input logic rdy6);
        drive(FETCH0, {4'h0, pc});
        drive(FETCH1, {op, opr});
        drive(c2, b2);
        drive(c3, b3);
        drive(c4, b4);
        drive('0, 8'h00);
        drive('0, 8'h00);
        trace_ready = rdy6;
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [20:0] exp);
        check({tag, "_valid"}, {31'b0, trace_valid}, 32'd1);
        check({tag, "_data"}, {11'b0, trace_data}, {11'b0, exp});
        @(negedge clk);
        trace_ready = 1'b1;
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        ctrl_word   = '0;
        bus         = 8'h00;
        alu_carry   = 1'b0;
        alu_zero    = 1'b0;
        trace_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",    {31'b0, trace_valid},    32'd0);
        check("rst_data",     {11'b0, trace_data},     32'd0);
        check("rst_overflow", {31'b0, trace_overflow}, 32'd0);
        check("rst_sync",     {31'b0, sync_lost},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LDA 0xE at pc=3, RAM[E]=0x2A
        instr(4'h3, OP_LDA, 4'hE, I_WRITE | MAR_READ, RAM_WRITE | A_READ, '0,
              8'h0E, 8'h2A, 8'h00, 1'b0);
        pop_check("lda", rec(1'b0, 4'h3, 4'h1, 4'hE, 8'h2A));
        check("lda_empty", {31'b0, trace_valid}, 32'd0);

        // JC not taken with carry=0: ctrl 0 is correct, bus noise not captured
        instr(4'h4, OP_JC, 4'h9, '0, '0, '0, 8'h55, 8'h55, 8'h55, 1'b0);
        pop_check("jc_nt", rec(1'b0, 4'h4, 4'h7, 4'h9, 8'h00));

        // JC forced jump with carry=0 -> error
        instr(4'h5, OP_JC, 4'h9, I_WRITE | PC_JUMP, '0, '0, 8'h09, 8'h00, 8'h00, 1'b0);
        pop_check("jc_bad", rec(1'b1, 4'h5, 4'h7, 4'h9, 8'h00));

        // JZ taken with zero=1 -> correct, data is bus at step 2
        alu_zero = 1'b1;
        instr(4'h6, OP_JZ, 4'h2, I_WRITE | PC_JUMP, '0, '0, 8'h02, 8'h00, 8'h00, 1'b0);
        alu_zero = 1'b0;
        pop_check("jz_t", rec(1'b0, 4'h6, 4'h8, 4'h2, 8'h02));

        // HLT at pc=F: pushed on the CLK_HLT edge
        drive(FETCH0, 8'h0F);
        drive(FETCH1, 8'hF0);
        drive(CLK_HLT, 8'h77);
        check("hlt_pre_valid", {31'b0, trace_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("hlt_valid", {31'b0, trace_valid}, 32'd1);
        drive('0, 8'h00);
        pop_check("hlt", rec(1'b0, 4'hF, 4'hF, 4'h0, 8'h77));

        // Fill FIFO with four LDI records, no consumer
        for (int i = 0; i < 4; i++) begin
            instr(4'(i), OP_LDI, 4'(i + 1), I_WRITE | A_READ, '0, '0,
                  8'(i + 1), 8'h00, 8'h00, 1'b0);
        end
        check("full_ovf0", {31'b0, trace_overflow}, 32'd0);
        // Fifth push coincides with a pop while full: both happen
        instr(4'h4, OP_LDI, 4'h5, I_WRITE | A_READ, '0, '0, 8'h05, 8'h00, 8'h00, 1'b1);
        check("pushpop_ovf0", {31'b0, trace_overflow}, 32'd0);
        // Sixth push while full with no pop: dropped
        instr(4'h5, OP_LDI, 4'h6, I_WRITE | A_READ, '0, '0, 8'h06, 8'h00, 8'h00, 1'b0);
        check("drop_ovf1", {31'b0, trace_overflow}, 32'd1);
        pop_check("drain1", rec(1'b0, 4'h1, 4'h5, 4'h2, 8'h02));
        pop_check("drain2", rec(1'b0, 4'h2, 4'h5, 4'h3, 8'h03));
        pop_check("drain3", rec(1'b0, 4'h3, 4'h5, 4'h4, 8'h04));
        pop_check("drain4", rec(1'b0, 4'h4, 4'h5, 4'h5, 8'h05));
        check("drain_empty", {31'b0, trace_valid}, 32'd0);
        check("drain_data0", {11'b0, trace_data}, 32'd0);

        // ADD at pc=7 interrupted by FETCH0 at step 4, then LDA C at pc=8
        drive(FETCH0, 8'h07);
        drive(FETCH1, 8'h2A);
        drive(I_WRITE | MAR_READ, 8'h0A);
        drive(RAM_WRITE | B_READ, 8'h11);
        check("pre_sync", {31'b0, sync_lost}, 32'd0);
        drive(FETCH0, 8'h08);
        @(posedge clk);
        #1;
        check("sync_lost", {31'b0, sync_lost}, 32'd1);
        check("sync_valid", {31'b0, trace_valid}, 32'd1);
        drive(FETCH1, 8'h1C);
        drive(I_WRITE | MAR_READ, 8'h0C);
        drive(RAM_WRITE | A_READ, 8'h99);
        drive('0, 8'h00);
        drive('0, 8'h00);
        drive('0, 8'h00);
        @(posedge clk);
        #1;
        pop_check("sync_add", rec(1'b1, 4'h7, 4'h2, 4'hA, 8'h11));
        pop_check("sync_lda", rec(1'b0, 4'h8, 4'h1, 4'hC, 8'h99));

        // Leave one record queued, start another, reset at step 3
        instr(4'h1, OP_LDA, 4'h4, I_WRITE | MAR_READ, RAM_WRITE | A_READ, '0,
              8'h04, 8'h5A, 8'h00, 1'b0);
        drive(FETCH0, 8'h02);
        drive(FETCH1, 8'h13);
        drive(I_WRITE | MAR_READ, 8'h03);
        drive(RAM_WRITE | A_READ, 8'h66);
        @(posedge clk);
        #1;
        check("prerst_valid", {31'b0, trace_valid}, 32'd1);
        check("prerst_ovf",   {31'b0, trace_overflow}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    {31'b0, trace_valid},    32'd0);
        check("arst_data",     {11'b0, trace_data},     32'd0);
        check("arst_overflow", {31'b0, trace_overflow}, 32'd0);
        check("arst_sync",     {31'b0, sync_lost},      32'd0);
        @(negedge clk);
        ctrl_word = '0;
        bus       = 8'h00;
        rst_n     = 1'b1;
        instr(4'h9, OP_LDA, 4'h3, I_WRITE | MAR_READ, RAM_WRITE | A_READ, '0,
              8'h03, 8'h44, 8'h00, 1'b0);
        pop_check("post_rst", rec(1'b0, 4'h9, 4'h1, 4'h3, 8'h44));
        check("post_rst_empty", {31'b0, trace_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
